// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU-side memory and I/O responder.
// The I/O window occupies address bits 17:16 == 2'b11.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_MASK = 18'h3_0000;
  localparam logic [17:0] IO_UART = 18'h3_0000;
  localparam logic [17:0] IO_CLK  = 18'h3_0004;
  localparam logic [17:0] IO_STOP = 18'h3_0004;

  // Source of the byte returned on the cycle after an I/O read
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_UART,
    RD_CLK
  } rd_sel_e;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// 8-bit synchronous FIFO of 2^DEPTH_LOG entries.
// Push on a full FIFO succeeds only if a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic [DEPTH_LOG:0]   count,
  output logic                 empty,
  output logic                 full
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [7:0]           storage [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = storage[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (do_push) storage[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory/I-O responder for the byte-wide CPU bus: 2^ADDR_WIDTH-byte RAM with
// one-cycle read latency, UART TX/RX FIFOs, cycle counter and program stop.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_wr,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int TX_DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] NEAR_FULL = (FIFO_DEPTH_LOG+1)'(TX_DEPTH - 2);

  logic [7:0]            ram [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_q;

  logic [17:0] io_addr;
  logic        io;
  logic        uart_wr, uart_rd, clk_rd, stop_wr;

  logic                    tx_push_req, tx_pop, tx_empty, tx_full;
  logic [7:0]              tx_din;
  logic [FIFO_DEPTH_LOG:0] tx_count;
  logic                    rx_empty, rx_full;
  logic [7:0]              rx_dout;
  logic [FIFO_DEPTH_LOG:0] rx_count;

  logic [31:0] cycle_cnt;
  logic [31:0] snapshot;
  logic [7:0]  uart_q;
  logic        io_sel_q;
  rd_sel_e     rd_sel_d, rd_sel_q;
  logic [1:0]  byte_sel_q;
  logic [7:0]  io_byte;
  logic        stop_pending, done_q, done_cond;
  logic        unused_ok;

  assign io_addr  = mem_a[17:0];
  assign io       = ((io_addr & IO_MASK) == IO_MASK);
  assign ram_addr = mem_a[ADDR_WIDTH-1:0];

  assign uart_wr  =  mem_wr && io && (io_addr == IO_UART);
  assign uart_rd  = !mem_wr && io && (io_addr == IO_UART);
  assign clk_rd   = !mem_wr && io && (io_addr == IO_CLK);
  assign stop_wr  =  mem_wr && io && (io_addr == IO_STOP);

  // A repeated stop write neither re-queues the marker nor re-arms anything
  assign tx_push_req = (uart_wr && (mem_wdata != 8'h00)) || (stop_wr && !stop_pending);
  assign tx_din      = stop_wr ? 8'h00 : mem_wdata;
  assign tx_valid    = !tx_empty;
  assign tx_pop      = tx_valid && tx_ready;

  assign io_buffer_full = (tx_count >= NEAR_FULL);
  assign done_cond      = stop_pending && tx_empty;
  assign program_done   = done_q || done_cond;

  byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push_req),
    .pop    (tx_pop),
    .din    (tx_din),
    .dout   (tx_data),
    .count  (tx_count),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid),
    .pop    (uart_rd),
    .din    (rx_data),
    .dout   (rx_dout),
    .count  (rx_count),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io) ram[ram_addr] <= mem_wdata;
    if (!mem_wr)       ram_q <= ram[ram_addr];
  end

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    rd_sel_d = RD_ZERO;
    if (io_addr == IO_UART)                 rd_sel_d = RD_UART;
    else if (io_addr[17:2] == IO_CLK[17:2]) rd_sel_d = RD_CLK;
  end

  // Reset selects the I/O path with RD_ZERO so an in-flight RAM read reads back as 0
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_sel_q   <= 1'b1;
      rd_sel_q   <= RD_ZERO;
      byte_sel_q <= 2'd0;
      uart_q     <= 8'h00;
      snapshot   <= 32'h0;
    end else if (!mem_wr) begin
      io_sel_q   <= io;
      rd_sel_q   <= rd_sel_d;
      byte_sel_q <= io_addr[1:0];
      if (uart_rd) uart_q   <= rx_empty ? 8'h00 : rx_dout;
      if (clk_rd)  snapshot <= cycle_cnt;
    end
  end

  always_comb begin
    io_byte = 8'h00;
    case (rd_sel_q)
      RD_UART: io_byte = uart_q;
      RD_CLK:  io_byte = snapshot[{byte_sel_q, 3'b000} +: 8];
      default: io_byte = 8'h00;
    endcase
  end

  assign mem_rdata = io_sel_q ? io_byte : ram_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt    <= 32'h0;
      stop_pending <= 1'b0;
      done_q       <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (stop_wr) stop_pending <= 1'b1;
      if (done_cond) done_q <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  assign unused_ok = ^{mem_a[31:18], rx_count, rx_full};

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, UART TX/RX,
// back-pressure, cycle-counter snapshot, program stop and async reset.
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0003_0010;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = IDLE_A;
  logic [7:0]  mem_wdata = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        program_done;
  logic        tx_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Cycles since reset release, used to predict the counter snapshot
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wdata = d; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0; mem_a = IDLE_A;
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] d);
    mem_a = a; mem_wr = 1'b0;
    step();
    d = mem_rdata;
    mem_a = IDLE_A;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_tx [4];

    #12;
    check("reset_rdata",    32'(mem_rdata), 32'h0);
    check("reset_full",     32'(io_buffer_full), 32'h0);
    check("reset_txvalid",  32'(tx_valid), 32'h0);
    check("reset_done",     32'(program_done), 32'h0);
    check("reset_overflow", 32'(tx_overflow), 32'h0);
    @(posedge clk_in); #1; rst_in = 1'b1;

    // RAM write then read, alias, write cycles hold mem_rdata
    wr(32'h0000_0123, 8'hA5);
    rd(32'h0000_0123, d); check("ram_rd",    32'(d), 32'hA5);
    rd(32'h0002_0123, d); check("ram_alias", 32'(d), 32'hA5);
    wr(32'h0000_0456, 8'h3C);
    check("ram_hold_on_wr", 32'(mem_rdata), 32'hA5);
    rd(32'h0003_0008, d); check("io_other_rd", 32'(d), 32'h00);
    rd(32'h0000_0456, d); check("ram_rd2",     32'(d), 32'h3C);

    // UART output: 0x00 to the UART port is ignored
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h69);
    wr(32'h0003_0000, 8'h00);
    check("tx_valid_q", 32'(tx_valid), 32'h1);
    check("tx_head_H",  32'(tx_data),  32'h48);
    tx_ready = 1'b1;
    step(); check("tx_head_i", 32'(tx_data), 32'h69);
    step(); check("tx_empty",  32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Back-pressure and overflow
    for (int i = 1; i <= 8; i++) begin
      wr(32'h0003_0000, 8'(8'h10 + i));
      if (i == 5) check("near_full_5", 32'(io_buffer_full), 32'h0);
      if (i == 6) check("near_full_6", 32'(io_buffer_full), 32'h1);
    end
    check("no_overflow_8", 32'(tx_overflow), 32'h0);
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h19);
    tx_ready = 1'b0;
    check("push_pop_full_ovf",  32'(tx_overflow), 32'h0);
    check("push_pop_full_head", 32'(tx_data), 32'h12);
    wr(32'h0003_0000, 8'h1A);
    check("overflow_9", 32'(tx_overflow), 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(tx_data), 32'(8'h12 + i));
      step();
    end
    check("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // RX input, empty read, simultaneous push and pop
    rx_data = 8'h7A; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    rd(32'h0003_0000, d); check("rx_7A",    32'(d), 32'h7A);
    rd(32'h0003_0000, d); check("rx_empty", 32'(d), 32'h00);
    rx_data = 8'h55; rx_valid = 1'b1; step();
    rx_data = 8'h66;
    rd(32'h0003_0000, d); rx_valid = 1'b0;
    check("rx_pp_55", 32'(d), 32'h55);
    rd(32'h0003_0000, d); check("rx_pp_66",   32'(d), 32'h66);
    rd(32'h0003_0000, d); check("rx_pp_none", 32'(d), 32'h00);

    // Program stop
    exp_tx = '{8'h01, 8'h02, 8'h03, 8'h00};
    wr(32'h0003_0000, 8'h01);
    wr(32'h0003_0000, 8'h02);
    wr(32'h0003_0000, 8'h03);
    wr(32'h0003_0004, 8'hEE);
    check("stop_not_done", 32'(program_done), 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stop_tx_%0d", i), 32'(tx_data), 32'(exp_tx[i]));
      check($sformatf("stop_wait_%0d", i), 32'(program_done), 32'h0);
      step();
    end
    check("stop_drained", 32'(tx_valid), 32'h0);
    check("stop_done",    32'(program_done), 32'h1);
    wr(32'h0003_0004, 8'h00);
    check("stop_again_txvalid", 32'(tx_valid), 32'h0);
    check("stop_again_done",    32'(program_done), 32'h1);
    tx_ready = 1'b0;

    // Async reset with a RAM read in flight
    rd(32'h0000_0123, d); check("pre_reset_rd", 32'(d), 32'hA5);
    mem_a = 32'h0000_0123;
    #3 rst_in = 1'b0;
    #1;
    check("async_done",     32'(program_done), 32'h0);
    check("async_overflow", 32'(tx_overflow), 32'h0);
    check("async_rdata",    32'(mem_rdata), 32'h0);
    mem_a = IDLE_A;
    @(posedge clk_in); #1; rst_in = 1'b1;
    rd(32'h0000_0123, d); check("ram_kept", 32'(d), 32'hA5);

    // Counter snapshot: latch at counter 0x1FF, then the live byte 1 moves on
    rst_in = 1'b0;
    @(posedge clk_in); #1; rst_in = 1'b1;
    for (int n = 0; n < 2000 && cyc != 511; n++) step();
    check("cnt_align", 32'(cyc), 32'd511);
    rd(32'h0003_0004, d); check("snap_b0", 32'(d), 32'hFF);
    rd(32'h0003_0005, d); check("snap_b1", 32'(d), 32'h01);
    rd(32'h0003_0006, d); check("snap_b2", 32'(d), 32'h00);
    rd(32'h0003_0007, d); check("snap_b3", 32'(d), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
